// File: rtl/param_ram_ctrl.sv
// Parameterised single-port RAM controller with manual read/write, a full-memory
// clear sweep and a slow auto-scan display mode.
module param_ram_ctrl #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 5,
    parameter int SCAN_DIV = 50_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              clr_req,
    input  logic              scan_en,
    output logic [DATA_W-1:0] q,
    output logic [ADDR_W-1:0] q_addr,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W-1:0] scan_ptr_r;
    logic [DIV_W-1:0]  div_r;

    logic              we_s;
    logic [ADDR_W-1:0] wa_s;
    logic [DATA_W-1:0] wd_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              clr_last_s;
    logic              div_tc_s;

    // Write-port mux: the sweep owns the port in CLEAR; clr_req drops a coincident user write.
    always_comb begin
        we_s = 1'b0;
        wa_s = address;
        wd_s = data;
        case (state_r)
            CLEAR: begin
                we_s = 1'b1;
                wa_s = clr_ptr_r;
                wd_s = {DATA_W{1'b0}};
            end
            IDLE, SCAN: begin
                we_s = wren & ~clr_req;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Read-port mux with write-through so a same-address write is visible next cycle.
    always_comb begin
        if (state_r == SCAN) begin
            rd_addr_s = scan_ptr_r;
        end else begin
            rd_addr_s = address;
        end
        if (we_s && (wa_s == rd_addr_s)) begin
            rd_data_s = wd_s;
        end else begin
            rd_data_s = mem_r[rd_addr_s];
        end
        clr_last_s = (clr_ptr_r == {ADDR_W{1'b1}});
        div_tc_s   = (div_r == DIV_W'(SCAN_DIV - 1));
    end

    // Memory array; deliberately outside reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    // Controller FSM with registered q, q_addr and busy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE;
            q          <= {DATA_W{1'b0}};
            q_addr     <= {ADDR_W{1'b0}};
            busy       <= 1'b0;
            clr_ptr_r  <= {ADDR_W{1'b0}};
            scan_ptr_r <= {ADDR_W{1'b0}};
            div_r      <= {DIV_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    q      <= rd_data_s;
                    q_addr <= rd_addr_s;
                    if (clr_req) begin
                        state_r   <= CLEAR;
                        busy      <= 1'b1;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end else if (scan_en) begin
                        state_r    <= SCAN;
                        scan_ptr_r <= {ADDR_W{1'b0}};
                        div_r      <= {DIV_W{1'b0}};
                    end
                end
                SCAN: begin
                    q      <= rd_data_s;
                    q_addr <= rd_addr_s;
                    if (clr_req) begin
                        state_r   <= CLEAR;
                        busy      <= 1'b1;
                        clr_ptr_r <= {ADDR_W{1'b0}};
                    end else if (!scan_en) begin
                        state_r    <= IDLE;
                        scan_ptr_r <= {ADDR_W{1'b0}};
                        div_r      <= {DIV_W{1'b0}};
                    end else if (div_tc_s) begin
                        div_r      <= {DIV_W{1'b0}};
                        scan_ptr_r <= scan_ptr_r + ADDR_W'(1'b1);
                    end else begin
                        div_r <= div_r + DIV_W'(1'b1);
                    end
                end
                CLEAR: begin
                    clr_ptr_r <= clr_ptr_r + ADDR_W'(1'b1);
                    if (clr_last_s) begin
                        busy       <= 1'b0;
                        state_r    <= scan_en ? SCAN : IDLE;
                        scan_ptr_r <= {ADDR_W{1'b0}};
                        div_r      <= {DIV_W{1'b0}};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_ram_ctrl.sv
// Self-checking bench for param_ram_ctrl (DATA_W=4, ADDR_W=5, SCAN_DIV=4):
// directed stimulus, a per-cycle reference model and literal spot checks.
module tb_param_ram_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [4:0] address;
    logic [3:0] data;
    logic       wren;
    logic       clr_req;
    logic       scan_en;
    logic [3:0] q;
    logic [4:0] q_addr;
    logic       busy;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    param_ram_ctrl #(.DATA_W(4), .ADDR_W(5), .SCAN_DIV(4)) dut (
        .clk(clk), .resetn(resetn), .address(address), .data(data),
        .wren(wren), .clr_req(clr_req), .scan_en(scan_en),
        .q(q), .q_addr(q_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: memory image, clear progress and elapsed scan edges.
    logic [3:0] m_mem [32];
    logic [3:0] exp_q;
    logic [4:0] exp_qa;
    logic       exp_busy;
    int         clr_idx;
    bit         scanning;
    int         scan_n;

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = 4'h0;
        exp_q = 4'h0; exp_qa = 5'h0; exp_busy = 1'b0;
        clr_idx = -1; scanning = 1'b0; scan_n = 0;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                exp_q = 4'h0; exp_qa = 5'h0; exp_busy = 1'b0;
                clr_idx = -1; scanning = 1'b0; scan_n = 0;
            end else if (clr_idx >= 0) begin
                m_mem[clr_idx] = 4'h0;
                clr_idx++;
                if (clr_idx == 32) begin
                    clr_idx  = -1;
                    exp_busy = 1'b0;
                    scanning = scan_en;
                    scan_n   = 0;
                end
            end else begin
                int rd;
                rd = scanning ? ((scan_n / 4) % 32) : int'(address);
                if (wren && !clr_req) m_mem[address] = data;
                exp_q  = m_mem[rd];
                exp_qa = 5'(rd);
                if (clr_req) begin
                    clr_idx  = 0;
                    exp_busy = 1'b1;
                    scanning = 1'b0;
                end else if (scanning) begin
                    if (!scan_en) scanning = 1'b0;
                    else scan_n++;
                end else if (scan_en) begin
                    scanning = 1'b1;
                    scan_n   = 0;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("model_q", int'(q), int'(exp_q));
                chk("model_q_addr", int'(q_addr), int'(exp_qa));
                chk("model_busy", int'(busy), int'(exp_busy));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        resetn = 1'b0; address = 5'h0; data = 4'h0;
        wren = 1'b0; clr_req = 1'b0; scan_en = 1'b0;
        tick(); tick();
        chk("reset_q", int'(q), 0);
        chk("reset_q_addr", int'(q_addr), 0);
        chk("reset_busy", int'(busy), 0);
        resetn = 1'b1;

        // Initialise memory; clr_req must be taken on the first edge after reset.
        clr_req = 1'b1; tick();
        chk("first_edge_busy", int'(busy), 1);
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("init_clear_done", int'(busy), 0);
        tick();
        cmp_en = 1'b1;

        // Basic write then read of 0x13.
        address = 5'h13; data = 4'hA; wren = 1'b1; tick();
        wren = 1'b0; address = 5'h02; tick();
        address = 5'h13; tick();
        chk("rd13_q", int'(q), 4'hA);
        chk("rd13_q_addr", int'(q_addr), 5'h13);

        // Read-during-write held two cycles.
        address = 5'h07; data = 4'h5; wren = 1'b1; tick();
        chk("rdw_q_first", int'(q), 4'h5);
        tick();
        chk("rdw_q_second", int'(q), 4'h5);
        wren = 1'b0;

        // Varied pattern written forward, read back in reverse.
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); data = 4'((i * 7 + 3) & 15); wren = 1'b1; tick();
        end
        wren = 1'b0;
        for (int i = 31; i >= 0; i--) begin address = 5'(i); tick(); end
        chk("pattern_rd0", int'(q), 4'h3);

        // Fill with 0xF then clear, with wren/clr_req noise during the sweep.
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); data = 4'hF; wren = 1'b1; tick();
        end
        address = 5'h05; data = 4'hA; wren = 1'b1; clr_req = 1'b1; tick();
        chk("clr_busy_rise", int'(busy), 1);
        n = 1;
        while (busy && n < 100) begin
            wren = (n < 20); data = 4'hF; address = 5'(n); clr_req = (n == 5);
            tick();
            if (busy) n++;
        end
        wren = 1'b0; clr_req = 1'b0;
        chk("clr_busy_cycles", n, 32);
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); tick();
            chk("after_clear_zero", int'(q), 0);
        end

        // Auto-scan over mem[i] = i[3:0].
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); data = 4'(i); wren = 1'b1; tick();
        end
        wren = 1'b0; address = 5'h05; scan_en = 1'b1; tick();
        for (int k = 1; k <= 132; k++) begin
            tick();
            if (k == 1)   begin chk("scan_k1_qa", int'(q_addr), 0);    chk("scan_k1_q", int'(q), 0);    end
            if (k == 4)   begin chk("scan_k4_qa", int'(q_addr), 0);    end
            if (k == 5)   begin chk("scan_k5_qa", int'(q_addr), 1);    chk("scan_k5_q", int'(q), 1);    end
            if (k == 125) begin chk("scan_k125_qa", int'(q_addr), 31); chk("scan_k125_q", int'(q), 15); end
            if (k == 129) begin chk("scan_wrap_qa", int'(q_addr), 0);  chk("scan_wrap_q", int'(q), 0);  end
        end
        address = 5'h01; data = 4'h9; wren = 1'b1; tick();
        chk("scan_wr_ptr_q", int'(q), 4'h9);
        chk("scan_wr_ptr_qa", int'(q_addr), 5'h01);
        wren = 1'b0; scan_en = 1'b0; tick();
        address = 5'h03; tick();
        chk("scan_exit_qa", int'(q_addr), 5'h03);
        chk("scan_exit_q", int'(q), 4'h3);
        scan_en = 1'b1; tick(); tick();
        chk("scan_reenter_qa", int'(q_addr), 0);
        scan_en = 1'b0; tick();

        // scan_en raised during the sweep: sweep ends in SCAN from pointer 0.
        clr_req = 1'b1; tick();
        clr_req = 1'b0; scan_en = 1'b1;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk("clr_to_scan_done", int'(busy), 0);
        tick();
        chk("clr_scan_qa0", int'(q_addr), 0);
        chk("clr_scan_q0", int'(q), 0);
        repeat (4) tick();
        chk("clr_scan_qa1", int'(q_addr), 1);
        chk("clr_scan_q1", int'(q), 0);
        scan_en = 1'b0; tick(); tick();

        // Reset after ten clear writes aborts the sweep.
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); data = 4'hC; wren = 1'b1; tick();
        end
        wren = 1'b0; clr_req = 1'b1; tick();
        clr_req = 1'b0;
        repeat (10) tick();
        resetn = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(q), 0);
        chk("abort_q_addr", int'(q_addr), 0);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            address = 5'(i); tick();
            chk("abort_mem", int'(q), (i < 10) ? 0 : 4'hC);
        end
        tick();

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
